instr_mem_ctrl: RTL and testbench

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

---
 rtl/imem_pkg.sv | 15 +
 rtl/mem_array_1rw.sv | 46 ++++
 rtl/instr_mem_ctrl.sv | 115 +++++++++++
 tb/tb_instr_mem_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction memory controller.
package imem_pkg;

    localparam int IMEM_DATA_W = 24;
    localparam int IMEM_ADDR_W = 16;
    localparam int IMEM_DEPTH  = 2048;
    localparam int IMEM_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port storage array: synchronous write, RD_LAT-stage registered read.
module mem_array_1rw #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 2048,
    parameter int RD_LAT = 1,
    parameter int AW     = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] pipe_q [RD_LAT];
    logic [DATA_W-1:0] pipe_d [RD_LAT];

    // Write port: the word is updated on the edge that carries the write.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read pipeline: stage 0 samples the array once per read, later stages shift,
    // so the launched word stays correct even if the address port changes.
    always_comb begin
        pipe_d = pipe_q;
        if (en && !we) begin
            pipe_d[0] = mem[addr];
        end
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers (data only, no reset needed).
    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
    end

    assign rdata = pipe_q[RD_LAT-1];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: one outstanding request, valid/ready on both sides.
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int RD_LAT = IMEM_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0]        LAT_M1    = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              in_range;
    logic              mem_en, mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range = ({1'b0, req_addr} < DEPTH_LIM);

    mem_array_1rw #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (req_addr[AW-1:0]),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );

    // Next-state, latency counter and response capture; array access only on acceptance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = ~in_range;
                    if (!in_range) begin
                        state_d = ST_RESP;
                    end else if (req_we) begin
                        // a write landing on an edge with rst high must not touch the array
                        mem_en  = ~rst;
                        mem_we  = ~rst;
                        state_d = ST_RESP;
                    end else begin
                        mem_en  = 1'b1;
                        cnt_d   = LAT_M1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = mem_rdata;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl (RD_LAT = 3, DEPTH = 2048).
module tb_instr_mem_ctrl;

    localparam int DW   = 24;
    localparam int AWD  = 16;
    localparam int LAT  = 3;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            hold;
        int            acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [AWD-1:0] req_addr = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t cur;
    logic in_rsp = 1'b0;
    logic hs_pending = 1'b0;
    int   hold_left = 0;

    instr_mem_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AWD),
        .DEPTH  (2048),
        .RD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, then push its expectation.
    task automatic issue(input logic we, input logic [AWD-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rdata, input logic exp_err, input int hold);
        exp_t e;
        int   budget;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        budget    = 0;
        while (!req_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stuck at 0, addr 0x%0h", addr);
            req_valid = 1'b0;
            return;
        end
        e.acc   = cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.hold  = hold;
        e.lat   = (we || exp_err) ? 1 : LAT + 1;
        @(posedge clk);
        sb.push_back(e);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AWD'($urandom);
        req_wdata = DW'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || in_rsp || hs_pending) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0 || in_rsp || hs_pending) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
        end
    endtask

    // Monitor: pops expectations when a response appears, checks stability and handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rsp     = 1'b0;
                hs_pending = 1'b0;
                rsp_ready  = 1'b0;
            end else begin
                if (hs_pending) begin
                    chk("idle_after_rsp", 32'(req_ready), 32'd1);
                    chk("valid_dropped", 32'(rsp_valid), 32'd0);
                    hs_pending = 1'b0;
                    in_rsp     = 1'b0;
                    rsp_ready  = 1'b0;
                end else if (rsp_valid && !in_rsp) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: rdata 0x%0h err %0d with nothing outstanding",
                                 rsp_rdata, rsp_err);
                    end else begin
                        cur = sb.pop_front();
                        in_rsp = 1'b1;
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
                        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                        chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        chk("ready_in_resp", 32'(req_ready), 32'd0);
                        hold_left = cur.hold;
                    end
                end else if (in_rsp) begin
                    chk("hold_valid", 32'(rsp_valid), 32'd1);
                    chk("hold_rdata", 32'(rsp_rdata), 32'(cur.rdata));
                    chk("hold_err", 32'(rsp_err), 32'(cur.err));
                    chk("hold_ready", 32'(req_ready), 32'd0);
                end else if (sb.size() != 0) begin
                    chk("busy_ready", 32'(req_ready), 32'd0);
                end
                if (in_rsp && !hs_pending) begin
                    if (hold_left == 0) begin
                        rsp_ready  = 1'b1;
                        hs_pending = 1'b1;
                    end else begin
                        hold_left--;
                    end
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // basic write/read, RD_LAT+1 read latency
        issue(1'b1, 16'd5,    24'h00ABCD, 24'h000000, 1'b0, 0);
        issue(1'b0, 16'd5,    24'h000000, 24'h00ABCD, 1'b0, 0);
        issue(1'b1, 16'd0,    24'h111111, 24'h000000, 1'b0, 0);
        issue(1'b0, 16'd0,    24'h000000, 24'h111111, 1'b0, 0);
        // out of range: error response, array untouched (2049 aliases addr 1)
        issue(1'b0, 16'd2048, 24'h000000, 24'h000000, 1'b1, 0);
        issue(1'b0, 16'd0,    24'h000000, 24'h111111, 1'b0, 0);
        issue(1'b1, 16'd1,    24'h0A0B0C, 24'h000000, 1'b0, 0);
        issue(1'b1, 16'd2049, 24'hFFFFFF, 24'h000000, 1'b1, 0);
        issue(1'b1, 16'hFFFF, 24'h123123, 24'h000000, 1'b1, 2);
        issue(1'b0, 16'd1,    24'h000000, 24'h0A0B0C, 1'b0, 0);
        // top legal address
        issue(1'b1, 16'd2047, 24'h7E7E7E, 24'h000000, 1'b0, 0);
        issue(1'b0, 16'd2047, 24'h000000, 24'h7E7E7E, 1'b0, 0);
        // back-pressure: response held 10 cycles
        issue(1'b0, 16'd5,    24'h000000, 24'h00ABCD, 1'b0, 10);
        // overwrite then read back
        issue(1'b1, 16'd5,    24'h5A5A5A, 24'h000000, 1'b0, 3);
        issue(1'b0, 16'd5,    24'h000000, 24'h5A5A5A, 1'b0, 1);
        issue(1'b1, 16'd7,    24'h123456, 24'h000000, 1'b0, 0);
        drain();

        // reset during WAIT drops the read; a write presented during reset is discarded
        issue(1'b0, 16'd7, 24'h000000, 24'h123456, 1'b0, 0);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'd7;
        req_wdata = 24'hDEAD00;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", 32'(req_ready), 32'd1);
        chk("valid_after_mid_rst", 32'(rsp_valid), 32'd0);
        repeat (6) @(negedge clk);
        issue(1'b0, 16'd7, 24'h000000, 24'h123456, 1'b0, 0);
        issue(1'b0, 16'd0, 24'h000000, 24'h111111, 1'b0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
